// File: rtl/demosaic_g_interp_gen2.sv
// Edge-directed green interpolator for Bayer R/B sites, four-stage pipeline with frame/line markers.
// Optional macro DEMOSAIC_GRAD_THRESH_EN adds a THRESH input that widens the averaging band.
module demosaic_g_interp_gen2 #(
    parameter int DW      = 8,
    parameter int COLS    = 512,
    parameter int LINES   = 768,
    parameter int PATTERN = 0
) (
    input  logic              INCLK,
    input  logic              RSTN,
    input  logic              IN_EN,
    input  logic              SOF,
    input  logic [DW-1:0]     UU,
    input  logic [DW-1:0]     UPDATA,
    input  logic [DW-1:0]     MID,
    input  logic [DW-1:0]     DOWNDATA,
    input  logic [DW-1:0]     DD,
    input  logic [DW-1:0]     LL,
    input  logic [DW-1:0]     LEFTDATA,
    input  logic [DW-1:0]     RIGHTDATA,
    input  logic [DW-1:0]     RR,
`ifdef DEMOSAIC_GRAD_THRESH_EN
    input  logic [DW+2:0]     THRESH,
`endif
    output logic              O_EN,
    output logic [3*DW-1:0]   O_DATA,
    output logic [1:0]        O_SITE,
    output logic              O_EOL,
    output logic              O_EOF
);

    localparam int SW = DW + 3;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);
    // Parity of the R pixel inside the 2x2 CFA tile; B sits on the opposite parity in both axes.
    localparam logic R_LINE = 1'((PATTERN / 2) % 2);
    localparam logic R_COL  = 1'(PATTERN % 2);

    typedef enum logic [1:0] {
        SITE_B = 2'b00,
        SITE_G = 2'b01,
        SITE_R = 2'b10
    } site_e;

    logic [CW-1:0] col_q, col_d, posCol;
    logic [LW-1:0] line_q, line_d, posLine;
    logic          sofHit, lastCol, lastLine;
    site_e         site;

    logic [DW-1:0]        absH, absV, halfH, halfV;
    logic signed [SW-1:0] lapH, lapV;

    logic                 v1_q, eol1_q, eof1_q;
    site_e                site1_q;
    logic [DW-1:0]        absH1_q, absV1_q, halfH1_q, halfV1_q, mid1_q;
    logic signed [SW-1:0] lapH1_q, lapV1_q;

    logic [SW-1:0]        absLapH, absLapV, dH, dV;
    logic signed [SW-1:0] gH, gV;

    logic                 v2_q, eol2_q, eof2_q;
    site_e                site2_q;
    logic [DW-1:0]        mid2_q;
    logic [SW-1:0]        dH2_q, dV2_q;
    logic signed [SW-1:0] gH2_q, gV2_q;

    logic signed [SW:0]   gSum;
    logic signed [SW-1:0] gAvg, gSel;
    logic                 useAvg;

    logic                 v3_q, eol3_q, eof3_q;
    site_e                site3_q;
    logic [DW-1:0]        mid3_q;
    logic signed [SW-1:0] g3_q;

    logic [DW-1:0]        gClamp;
    logic [3*DW-1:0]      outData;

    // A qualified SOF forces the current pixel to (0,0) and the counters continue from there.
    always_comb begin
        sofHit   = SOF & IN_EN;
        posCol   = sofHit ? '0 : col_q;
        posLine  = sofHit ? '0 : line_q;
        lastCol  = (posCol == COL_LAST);
        lastLine = (posLine == LINE_LAST);
        col_d    = col_q;
        line_d   = line_q;
        if (IN_EN) begin
            col_d = lastCol ? '0 : posCol + CW'(1);
            if (lastCol) begin
                line_d = lastLine ? '0 : posLine + LW'(1);
            end else begin
                line_d = posLine;
            end
        end
        if ((posLine[0] == R_LINE) && (posCol[0] == R_COL)) begin
            site = SITE_R;
        end else if ((posLine[0] != R_LINE) && (posCol[0] != R_COL)) begin
            site = SITE_B;
        end else begin
            site = SITE_G;
        end
    end

    always_comb begin
        absH  = (LEFTDATA >= RIGHTDATA) ? LEFTDATA - RIGHTDATA : RIGHTDATA - LEFTDATA;
        absV  = (UPDATA >= DOWNDATA) ? UPDATA - DOWNDATA : DOWNDATA - UPDATA;
        lapH  = $signed({2'b00, MID, 1'b0}) - $signed({3'b000, LL}) - $signed({3'b000, RR});
        lapV  = $signed({2'b00, MID, 1'b0}) - $signed({3'b000, UU}) - $signed({3'b000, DD});
        halfH = DW'(({1'b0, LEFTDATA} + {1'b0, RIGHTDATA}) >> 1);
        halfV = DW'(({1'b0, UPDATA} + {1'b0, DOWNDATA}) >> 1);
    end

    always_comb begin
        absLapH = lapH1_q[SW-1] ? $unsigned(-lapH1_q) : $unsigned(lapH1_q);
        absLapV = lapV1_q[SW-1] ? $unsigned(-lapV1_q) : $unsigned(lapV1_q);
        dH      = {3'b000, absH1_q} + absLapH;
        dV      = {3'b000, absV1_q} + absLapV;
        gH      = $signed({3'b000, halfH1_q}) + (lapH1_q >>> 2);
        gV      = $signed({3'b000, halfV1_q}) + (lapV1_q >>> 2);
    end

    // The average is floored, so a negative odd sum rounds toward minus infinity.
    always_comb begin
        gSum = $signed({gH2_q[SW-1], gH2_q}) + $signed({gV2_q[SW-1], gV2_q});
        gAvg = SW'(gSum >>> 1);
`ifdef DEMOSAIC_GRAD_THRESH_EN
        useAvg = (((dH2_q >= dV2_q) ? dH2_q - dV2_q : dV2_q - dH2_q) <= THRESH);
`else
        useAvg = (dH2_q == dV2_q);
`endif
        if (useAvg) begin
            gSel = gAvg;
        end else if (dH2_q < dV2_q) begin
            gSel = gH2_q;
        end else begin
            gSel = gV2_q;
        end
    end

    always_comb begin
        if (g3_q[SW-1]) begin
            gClamp = '0;
        end else if (|g3_q[SW-2:DW]) begin
            gClamp = '1;
        end else begin
            gClamp = g3_q[DW-1:0];
        end
        case (site3_q)
            SITE_R:  outData = {mid3_q, gClamp, {DW{1'b0}}};
            SITE_B:  outData = {{DW{1'b0}}, gClamp, mid3_q};
            default: outData = {{DW{1'b0}}, mid3_q, {DW{1'b0}}};
        endcase
    end

    // Free-running pipeline: valids shift every cycle, so bubbles travel with the data.
    always_ff @(posedge INCLK or negedge RSTN) begin
        if (!RSTN) begin
            col_q    <= '0;
            line_q   <= '0;
            v1_q     <= 1'b0;
            absH1_q  <= '0;
            absV1_q  <= '0;
            halfH1_q <= '0;
            halfV1_q <= '0;
            lapH1_q  <= '0;
            lapV1_q  <= '0;
            mid1_q   <= '0;
            site1_q  <= SITE_B;
            eol1_q   <= 1'b0;
            eof1_q   <= 1'b0;
            v2_q     <= 1'b0;
            dH2_q    <= '0;
            dV2_q    <= '0;
            gH2_q    <= '0;
            gV2_q    <= '0;
            mid2_q   <= '0;
            site2_q  <= SITE_B;
            eol2_q   <= 1'b0;
            eof2_q   <= 1'b0;
            v3_q     <= 1'b0;
            g3_q     <= '0;
            mid3_q   <= '0;
            site3_q  <= SITE_B;
            eol3_q   <= 1'b0;
            eof3_q   <= 1'b0;
            O_EN     <= 1'b0;
            O_DATA   <= '0;
            O_SITE   <= 2'b00;
            O_EOL    <= 1'b0;
            O_EOF    <= 1'b0;
        end else begin
            col_q    <= col_d;
            line_q   <= line_d;
            v1_q     <= IN_EN;
            absH1_q  <= absH;
            absV1_q  <= absV;
            halfH1_q <= halfH;
            halfV1_q <= halfV;
            lapH1_q  <= lapH;
            lapV1_q  <= lapV;
            mid1_q   <= MID;
            site1_q  <= site;
            eol1_q   <= lastCol;
            eof1_q   <= lastCol & lastLine;
            v2_q     <= v1_q;
            dH2_q    <= dH;
            dV2_q    <= dV;
            gH2_q    <= gH;
            gV2_q    <= gV;
            mid2_q   <= mid1_q;
            site2_q  <= site1_q;
            eol2_q   <= eol1_q;
            eof2_q   <= eof1_q;
            v3_q     <= v2_q;
            g3_q     <= gSel;
            mid3_q   <= mid2_q;
            site3_q  <= site2_q;
            eol3_q   <= eol2_q;
            eof3_q   <= eof2_q;
            O_EN     <= v3_q;
            O_EOL    <= v3_q & eol3_q;
            O_EOF    <= v3_q & eof3_q;
            if (v3_q) begin
                O_DATA <= outData;
                O_SITE <= site3_q;
            end
        end
    end

endmodule
